// File: rtl/sd_sched_pkg.sv
// Shared constants for the SD timeout scheduler: channel geometry, bus widths
// and the register word addresses.
package sd_sched_pkg;
   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;
   localparam int BUS_AW = 3;
   localparam int BUS_DW = 16;

   localparam logic [BUS_AW-1:0] ADDR_STATUS  = 3'd0;
   localparam logic [BUS_AW-1:0] ADDR_CONTROL = 3'd1;
   localparam logic [BUS_AW-1:0] ADDR_ACTIVE  = 3'd2;
   localparam logic [BUS_AW-1:0] ADDR_CH_BASE = 3'd4;
endpackage

// File: rtl/sd_timeout_sched_if.sv
// Avalon-MM slave bus plus interrupt line of the SD timeout scheduler.
interface sd_timeout_sched_if;
   import sd_sched_pkg::*;

   logic [BUS_AW-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [BUS_DW-1:0] writedata;
   logic [BUS_DW-1:0] readdata;
   logic              irq;

   modport master (output address, chipselect, write_n, writedata,
                   input  readdata, irq);
   modport slave  (input  address, chipselect, write_n, writedata,
                   output readdata, irq);
endinterface

// File: rtl/sd_sched_channel.sv
// One timeout channel: remaining count, reload value and running flag; pulses
// o_expire on the tick that takes the count through 1.
module sd_sched_channel #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_tick,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_auto_reload,
   output logic [CNT_W-1:0] o_count,
   output logic             o_active,
   output logic             o_expire
);
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_reload;
   logic             r_active;
   logic             w_step;
   logic             w_last;

   // A load in the same cycle as a tick suppresses both decrement and expiry.
   assign w_step   = i_tick && r_active && !i_load;
   assign w_last   = (r_count == CNT_W'(1));
   assign o_expire = w_step && w_last;
   assign o_count  = r_count;
   assign o_active = r_active;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count  <= '0;
         r_reload <= '0;
         r_active <= 1'b0;
      end else if (i_load) begin
         r_count  <= i_load_val;
         r_reload <= i_load_val;
         r_active <= (i_load_val != '0);
      end else if (w_step) begin
         if (!w_last) begin
            r_count <= r_count - CNT_W'(1);
         end else if (i_auto_reload) begin
            r_count <= r_reload;
         end else begin
            r_count  <= '0;
            r_active <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/sd_timeout_sched.sv
// SD timeout scheduler: register decode, STATUS/CONTROL, registered read mux
// and level interrupt around NUM_CH tick-driven countdown channels.
module sd_timeout_sched
   import sd_sched_pkg::*;
#(
   parameter int NUM_CH = sd_sched_pkg::NUM_CH,
   parameter int CNT_W  = sd_sched_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               tick,
   sd_timeout_sched_if.slave  bus
);
   logic                  w_wr;
   logic [NUM_CH-1:0]     w_load;
   logic [NUM_CH-1:0]     w_active;
   logic [NUM_CH-1:0]     w_expire;
   logic [NUM_CH-1:0]     w_clr;
   logic [CNT_W-1:0]      w_count [NUM_CH];
   logic [BUS_DW-1:0]     w_rdata;
   logic [NUM_CH-1:0]     r_expired;
   logic [2*NUM_CH-1:0]   r_ctrl;
   logic [BUS_DW-1:0]     r_rdata;

   assign w_wr  = bus.chipselect && !bus.write_n;
   assign w_clr = (w_wr && bus.address == ADDR_STATUS) ? bus.writedata[NUM_CH-1:0] : '0;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      assign w_load[n] = w_wr && (bus.address == ADDR_CH_BASE + BUS_AW'(n));

      sd_sched_channel #(.CNT_W(CNT_W)) u_ch (
         .clk           (clk),
         .reset_n       (reset_n),
         .i_tick        (tick),
         .i_load        (w_load[n]),
         .i_load_val    (bus.writedata[CNT_W-1:0]),
         .i_auto_reload (r_ctrl[NUM_CH+n]),
         .o_count       (w_count[n]),
         .o_active      (w_active[n]),
         .o_expire      (w_expire[n])
      );
   end

   always_comb begin
      w_rdata = '0;
      case (bus.address)
         ADDR_STATUS:  w_rdata = BUS_DW'(r_expired);
         ADDR_CONTROL: w_rdata = BUS_DW'(r_ctrl);
         ADDR_ACTIVE:  w_rdata = BUS_DW'(w_active);
         default:      w_rdata = '0;
      endcase
      for (int n = 0; n < NUM_CH; n++) begin
         if (bus.address == ADDR_CH_BASE + BUS_AW'(n)) w_rdata = BUS_DW'(w_count[n]);
      end
   end

   // Expiry is OR'd in after the clear so a same-cycle expiry keeps its flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_expired <= '0;
         r_ctrl    <= '0;
         r_rdata   <= '0;
      end else begin
         if (w_wr && bus.address == ADDR_CONTROL) r_ctrl <= bus.writedata[2*NUM_CH-1:0];
         r_expired <= w_expire | (r_expired & ~w_clr);
         r_rdata   <= w_rdata;
      end
   end

   assign bus.readdata = r_rdata;
   assign bus.irq      = |(r_expired & r_ctrl[NUM_CH-1:0]);
endmodule

// File: tb/tb_sd_timeout_sched.sv
// Directed bench for sd_timeout_sched: register map, countdown, reload,
// collision priorities and asynchronous reset.
module tb_sd_timeout_sched;
   import sd_sched_pkg::*;

   logic clk;
   logic reset_n;
   logic tick;
   int   n_assert = 0;
   int   n_fail   = 0;

   sd_timeout_sched_if bus ();

   sd_timeout_sched #(.NUM_CH(4), .CNT_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   task automatic wr_tick(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      tick = 1'b1;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write_n = 1'b1; tick = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
      @(negedge clk);
      bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
      @(posedge clk);
      #1;
      chk(tag, bus.readdata, exp);
      bus.chipselect = 1'b0;
   endtask

   task automatic pulse(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   endtask

   task automatic irq_chk(input string tag, input logic exp);
      @(negedge clk);
      chk(tag, {15'b0, bus.irq}, {15'b0, exp});
   endtask

   initial begin
      reset_n = 1'b0; tick = 1'b0;
      bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
      repeat (3) @(negedge clk);
      chk("rst_readdata", bus.readdata, 16'h0);
      chk("rst_irq", {15'b0, bus.irq}, 16'h0);
      reset_n = 1'b1;
      rd_chk("rst_status", ADDR_STATUS, 16'h0);
      rd_chk("rst_control", ADDR_CONTROL, 16'h0);
      rd_chk("rst_ch0", 3'd4, 16'h0);

      // one-shot ch0 with irq
      wr(3'd4, 16'd3);
      wr(ADDR_CONTROL, 16'h0001);
      rd_chk("t1_ctrl", ADDR_CONTROL, 16'h0001);
      rd_chk("t1_active0", ADDR_ACTIVE, 16'h0001);
      pulse(1); rd_chk("t1_cnt2", 3'd4, 16'd2);
      pulse(1); rd_chk("t1_cnt1", 3'd4, 16'd1);
      irq_chk("t1_irq_pre", 1'b0);
      pulse(1); rd_chk("t1_status", ADDR_STATUS, 16'h0001);
      irq_chk("t1_irq", 1'b1);
      rd_chk("t1_active", ADDR_ACTIVE, 16'h0000);
      rd_chk("t1_cnt0", 3'd4, 16'd0);
      pulse(2); rd_chk("t1_nowrap", 3'd4, 16'd0);
      wr(3'd3, 16'hFFFF); rd_chk("t1_rsvd", 3'd3, 16'h0);
      wr(ADDR_ACTIVE, 16'hFFFF); rd_chk("t1_active_ro", ADDR_ACTIVE, 16'h0);
      wr(ADDR_STATUS, 16'h0001);
      rd_chk("t1_clr", ADDR_STATUS, 16'h0);
      irq_chk("t1_irq_clr", 1'b0);

      // auto-reload ch0, irq disabled
      wr(ADDR_CONTROL, 16'h0010);
      wr(3'd4, 16'd2);
      pulse(1); rd_chk("t2_st1", ADDR_STATUS, 16'h0);
      pulse(1); rd_chk("t2_st2", ADDR_STATUS, 16'h0001);
      rd_chk("t2_reload2", 3'd4, 16'd2);
      irq_chk("t2_irq2", 1'b0);
      wr(ADDR_STATUS, 16'h0001);
      pulse(1); rd_chk("t2_st3", ADDR_STATUS, 16'h0);
      rd_chk("t2_cnt3", 3'd4, 16'd1);
      pulse(1); rd_chk("t2_st4", ADDR_STATUS, 16'h0001);
      rd_chk("t2_reload4", 3'd4, 16'd2);
      rd_chk("t2_active", ADDR_ACTIVE, 16'h0001);
      irq_chk("t2_irq4", 1'b0);
      wr(3'd4, 16'd0);
      rd_chk("t2_stop", ADDR_ACTIVE, 16'h0);
      wr(ADDR_STATUS, 16'h000F);
      wr(ADDR_CONTROL, 16'h0000);

      // load beats a same-cycle tick (ch1 at 1 would otherwise expire)
      wr(3'd5, 16'd1);
      wr_tick(3'd5, 16'd5);
      rd_chk("t3_cnt5", 3'd5, 16'd5);
      rd_chk("t3_noexp", ADDR_STATUS, 16'h0);
      pulse(4); rd_chk("t3_st4", ADDR_STATUS, 16'h0);
      rd_chk("t3_cnt1", 3'd5, 16'd1);
      pulse(1); rd_chk("t3_st5", ADDR_STATUS, 16'h0002);
      wr(ADDR_STATUS, 16'h0002);

      // expiry beats a same-cycle STATUS clear
      wr(ADDR_CONTROL, 16'h0001);
      wr(3'd4, 16'd1);
      wr_tick(ADDR_STATUS, 16'h0001);
      rd_chk("t4_keep", ADDR_STATUS, 16'h0001);
      irq_chk("t4_irq", 1'b1);
      wr(ADDR_STATUS, 16'h0001);
      rd_chk("t4_clr", ADDR_STATUS, 16'h0);
      irq_chk("t4_irq_clr", 1'b0);

      // all channels staggered
      wr(3'd4, 16'd1); wr(3'd5, 16'd2); wr(3'd6, 16'd3); wr(3'd7, 16'd4);
      wr(ADDR_CONTROL, 16'h000F);
      rd_chk("t5_active", ADDR_ACTIVE, 16'h000F);
      pulse(1); rd_chk("t5_s1", ADDR_STATUS, 16'h0001);
      pulse(1); rd_chk("t5_s2", ADDR_STATUS, 16'h0003);
      pulse(1); rd_chk("t5_s3", ADDR_STATUS, 16'h0007);
      pulse(1); rd_chk("t5_s4", ADDR_STATUS, 16'h000F);
      irq_chk("t5_irq", 1'b1);
      wr(ADDR_STATUS, 16'h000F);
      wr(3'd6, 16'd3); wr(3'd7, 16'd3);
      pulse(1);
      wr(3'd6, 16'd0);
      rd_chk("t5_act_ch2off", ADDR_ACTIVE, 16'h0008);
      pulse(2); rd_chk("t5_s_ch3only", ADDR_STATUS, 16'h0008);
      rd_chk("t5_ch2cnt", 3'd6, 16'd0);
      wr(ADDR_STATUS, 16'h000F);

      // asynchronous reset mid-count
      wr(3'd5, 16'd1);
      wr(3'd4, 16'd10);
      pulse(3);
      rd_chk("t6_cnt7", 3'd4, 16'd7);
      irq_chk("t6_irq_pre", 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_rd", bus.readdata, 16'h0);
      chk("t6_rst_irq", {15'b0, bus.irq}, 16'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rd_chk("t6_ch0", 3'd4, 16'h0);
      rd_chk("t6_ctrl", ADDR_CONTROL, 16'h0);
      rd_chk("t6_active", ADDR_ACTIVE, 16'h0);
      pulse(10);
      rd_chk("t6_noexp", ADDR_STATUS, 16'h0);
      irq_chk("t6_irq", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
